// File: rtl/kinematics_arbiter_pkg.sv
// ============================================================================
// kinematics_arbiter_pkg : shared types and widths for the kinematics arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package kinematics_arbiter_pkg;

    localparam int THETA_W          = 13;
    localparam int COORD_W          = 14;
    localparam int ENG_RESET_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_BUSY    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_FLUSH   = 3'd5
    } kin_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/kinematics_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, first set request after last_id
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_id,
    output logic [IDW-1:0]   id,
    output logic             found
);

    int idx;

    // Scan starts one past the previous winner and wraps, so the last winner
    // has the lowest priority.
    always_comb begin
        found = 1'b0;
        id    = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_id) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = IDW'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/kinematics_arbiter.sv
// ============================================================================
// kinematics_arbiter : round-robin sharing of one forward-kinematics engine.
// Optional engine watchdog and FLUSH recovery: define KIN_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module kinematics_arbiter
    import kinematics_arbiter_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int ENABLE_HOLD = 2,
    parameter int TIMEOUT     = 200
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*THETA_W-1:0]     theta1_in,
    input  logic [N_REQ*THETA_W-1:0]     theta2_in,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [COORD_W-1:0]           rsp_x,
    output logic [COORD_W-1:0]           rsp_y,
    output logic                         rsp_err,
    output logic                         busy,
    output logic signed [THETA_W-1:0]    eng_theta1,
    output logic signed [THETA_W-1:0]    eng_theta2,
    output logic                         eng_enable,
    output logic                         eng_reset,
    input  logic [COORD_W-1:0]           eng_x,
    input  logic [COORD_W-1:0]           eng_y,
    input  logic                         eng_data_ready
);

    localparam int IDW    = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(ENABLE_HOLD + 1);
    localparam int ERST_W = $clog2(ENG_RESET_CYCLES + 1);

    kin_arb_state_t              state_q, state_d;
    logic [IDW-1:0]              id_q, id_d;
    logic [IDW-1:0]              last_id_q, last_id_d;
    logic [N_REQ-1:0]            gnt_q, gnt_d;
    logic [N_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [COORD_W-1:0]          rsp_x_q, rsp_x_d;
    logic [COORD_W-1:0]          rsp_y_q, rsp_y_d;
    logic signed [THETA_W-1:0]   theta1_q, theta1_d;
    logic signed [THETA_W-1:0]   theta2_q, theta2_d;
    logic [HOLD_W-1:0]           hold_q, hold_d;
    logic [ERST_W-1:0]           erst_q, erst_d;

    logic [IDW-1:0]              pick_id;
    logic                        pick_found;

`ifdef KIN_ARB_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TMO_W-1:0]            tmo_q, tmo_d;
    logic                        rsp_err_q, rsp_err_d;
`endif

    rr_pick #(
        .N_REQ   (N_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req     (req),
        .last_id (last_id_q),
        .id      (pick_id),
        .found   (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        last_id_d   = last_id_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_x_d     = rsp_x_q;
        rsp_y_d     = rsp_y_q;
        theta1_d    = theta1_q;
        theta2_d    = theta2_q;
        hold_d      = hold_q;
        erst_d      = (erst_q != '0) ? erst_q - 1'b1 : erst_q;
`ifdef KIN_ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            // No grant while the engine is still held in reset.
            ST_IDLE: begin
                if (pick_found && erst_q == '0) begin
                    gnt_d[pick_id] = 1'b1;
                    theta1_d       = theta1_in[THETA_W*int'(pick_id) +: THETA_W];
                    theta2_d       = theta2_in[THETA_W*int'(pick_id) +: THETA_W];
                    id_d           = pick_id;
                    hold_d         = '0;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (hold_q == HOLD_W'(ENABLE_HOLD - 1)) begin
                    state_d = ST_BUSY;
`ifdef KIN_ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_BUSY: begin
                if (eng_data_ready) begin
                    rsp_x_d           = eng_x;
                    rsp_y_d           = eng_y;
                    rsp_valid_d[id_q] = 1'b1;
                    state_d           = ST_DELIVER;
`ifdef KIN_ARB_TIMEOUT_EN
                    rsp_err_d         = 1'b0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    erst_d  = ERST_W'(ENG_RESET_CYCLES);
                    state_d = ST_FLUSH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            ST_DELIVER: begin
                last_id_d = id_q;
                state_d   = ST_DRAIN;
            end
            // A stretched ready must not be mistaken for the next job's result.
            ST_DRAIN: begin
                if (!eng_data_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef KIN_ARB_TIMEOUT_EN
            ST_FLUSH: begin
                if (erst_q == ERST_W'(1)) begin
                    rsp_valid_d[id_q] = 1'b1;
                    rsp_err_d         = 1'b1;
                    rsp_x_d           = '0;
                    rsp_y_d           = '0;
                    last_id_d         = id_q;
                    state_d           = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            last_id_q   <= IDW'(N_REQ - 1);
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            theta1_q    <= '0;
            theta2_q    <= '0;
            hold_q      <= '0;
            erst_q      <= ERST_W'(ENG_RESET_CYCLES);
`ifdef KIN_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            last_id_q   <= last_id_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            theta1_q    <= theta1_d;
            theta2_q    <= theta2_d;
            hold_q      <= hold_d;
            erst_q      <= erst_d;
`ifdef KIN_ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_x      = rsp_x_q;
    assign rsp_y      = rsp_y_q;
    assign busy       = (state_q != ST_IDLE);
    assign eng_theta1 = theta1_q;
    assign eng_theta2 = theta2_q;
    assign eng_enable = (state_q == ST_ISSUE);
    assign eng_reset  = (erst_q != '0);
`ifdef KIN_ARB_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kinematics_arbiter.sv
// ============================================================================
// tb_kinematics_arbiter : directed self-checking bench for kinematics_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_kinematics_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req = '0;
    logic [38:0] theta1_in = '0;
    logic [38:0] theta2_in = '0;
    logic [2:0]  gnt, rsp_valid;
    logic [13:0] rsp_x, rsp_y;
    logic        rsp_err, busy, eng_enable, eng_reset;
    logic signed [12:0] eng_theta1, eng_theta2;
    logic [13:0] eng_x = '0;
    logic [13:0] eng_y = '0;
    logic        eng_data_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kinematics_arbiter #(
        .N_REQ          (3),
        .ENABLE_HOLD    (2),
        .TIMEOUT        (200)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .theta1_in      (theta1_in),
        .theta2_in      (theta2_in),
        .gnt            (gnt),
        .rsp_valid      (rsp_valid),
        .rsp_x          (rsp_x),
        .rsp_y          (rsp_y),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .eng_theta1     (eng_theta1),
        .eng_theta2     (eng_theta2),
        .eng_enable     (eng_enable),
        .eng_reset      (eng_reset),
        .eng_x          (eng_x),
        .eng_y          (eng_y),
        .eng_data_ready (eng_data_ready)
    );

    task automatic set_theta(input int i, input logic [12:0] t1, input logic [12:0] t2);
        theta1_in[13*i +: 13] = t1;
        theta2_in[13*i +: 13] = t2;
    endtask

    task automatic wait_gnt(output logic [2:0] g, output bit to);
        to = 1'b1;
        g  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt !== 3'b000) begin
                g  = gnt;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic engine_pulse(input logic [13:0] x, input logic [13:0] y);
        eng_x = x;
        eng_y = y;
        eng_data_ready = 1'b1;
        @(negedge clk);
        eng_data_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({gnt, rsp_valid, rsp_err, busy, eng_enable} !== 9'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 0", {gnt, rsp_valid, rsp_err, busy, eng_enable}); end
        total++; if ({rsp_x, rsp_y} !== 28'b0) begin bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_x, rsp_y}); end
        total++; if ({eng_theta1, eng_theta2} !== 26'b0) begin bad++; $display("FAIL reset_theta: got %h want 0", {eng_theta1, eng_theta2}); end
        total++; if (eng_reset !== 1'b1) begin bad++; $display("FAIL reset_eng_reset: got %b want 1", eng_reset); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (eng_reset !== 1'b1) begin bad++; $display("FAIL eng_reset_tail: got %b want 1", eng_reset); end
        @(negedge clk);
        total++; if (eng_reset !== 1'b0) begin bad++; $display("FAIL eng_reset_release: got %b want 0", eng_reset); end
    endtask

    task automatic test_single();
        logic [2:0] g;
        bit         to;
        set_theta(1, 13'd100, -13'sd50);
        req = 3'b010;
        wait_gnt(g, to);
        total++; if (to || g !== 3'b010) begin bad++; $display("FAIL single_gnt: got %b want 010", g); end
        total++; if (eng_theta1 !== 13'sd100 || eng_theta2 !== -13'sd50) begin bad++; $display("FAIL single_theta: got %0d/%0d want 100/-50", eng_theta1, eng_theta2); end
        total++; if (eng_enable !== 1'b1) begin bad++; $display("FAIL single_en1: got %b want 1", eng_enable); end
        req = 3'b000;
        set_theta(1, 13'd7, 13'd7);
        @(negedge clk);
        total++; if (eng_enable !== 1'b1 || gnt !== 3'b000) begin bad++; $display("FAIL single_en2: got en=%b gnt=%b want 1/000", eng_enable, gnt); end
        @(negedge clk);
        total++; if (eng_enable !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_busy: got en=%b busy=%b want 0/1", eng_enable, busy); end
        repeat (111) @(negedge clk);
        total++; if (eng_theta1 !== 13'sd100) begin bad++; $display("FAIL single_theta_hold: got %0d want 100", eng_theta1); end
        engine_pulse(14'h0ABC, 14'h0123);
        total++; if (rsp_valid !== 3'b010 || rsp_x !== 14'h0ABC || rsp_y !== 14'h0123 || rsp_err !== 1'b0) begin bad++; $display("FAIL single_rsp: got v=%b x=%h y=%h e=%b want 010/0abc/0123/0", rsp_valid, rsp_x, rsp_y, rsp_err); end
        @(negedge clk);
        total++; if (rsp_valid !== 3'b000) begin bad++; $display("FAIL single_rsp_pulse: got %b want 000", rsp_valid); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || rsp_x !== 14'h0ABC) begin bad++; $display("FAIL single_idle: got busy=%b x=%h want 0/0abc", busy, rsp_x); end
    endtask

    task automatic test_fairness();
        logic [2:0] g;
        bit         to;
        int         e;
        apply_reset();
        for (int i = 0; i < 3; i++) set_theta(i, 13'(10 + i), 13'(20 + i));
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            e = k % 3;
            wait_gnt(g, to);
            total++; if (to || g !== 3'(1 << e)) begin bad++; $display("FAIL fair_gnt%0d: got %b want %b", k, g, 3'(1 << e)); end
            total++; if (eng_theta1 !== 13'(10 + e)) begin bad++; $display("FAIL fair_theta%0d: got %0d want %0d", k, eng_theta1, 10 + e); end
            repeat (2) @(negedge clk);
            engine_pulse(14'(100 + k), 14'(200 + k));
            total++; if (rsp_valid !== 3'(1 << e) || rsp_x !== 14'(100 + k)) begin bad++; $display("FAIL fair_rsp%0d: got v=%b x=%0d want %b/%0d", k, rsp_valid, rsp_x, 3'(1 << e), 100 + k); end
            if (k == 5) req = 3'b000;
        end
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_stretched();
        logic [2:0] g;
        bit         to;
        int         rsp_n;
        bit         early;
        rsp_n = 0;
        early = 1'b0;
        req = 3'b011;
        wait_gnt(g, to);
        total++; if (to || g !== 3'b001) begin bad++; $display("FAIL stretch_gnt0: got %b want 001", g); end
        req = 3'b010;
        repeat (2) @(negedge clk);
        eng_x = 14'h0111;
        eng_y = 14'h0222;
        eng_data_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 3'b000) rsp_n++;
            if (gnt !== 3'b000) early = 1'b1;
        end
        eng_data_ready = 1'b0;
        wait_gnt(g, to);
        total++; if (rsp_n != 1) begin bad++; $display("FAIL stretch_rsp_count: got %0d want 1", rsp_n); end
        total++; if (early || to || g !== 3'b010) begin bad++; $display("FAIL stretch_next_gnt: got %b early=%b want 010 after ready fall", g, early); end
        req = 3'b000;
        repeat (2) @(negedge clk);
        engine_pulse(14'h0333, 14'h0444);
        total++; if (rsp_valid !== 3'b010 || rsp_x !== 14'h0333) begin bad++; $display("FAIL stretch_rsp1: got v=%b x=%h want 010/0333", rsp_valid, rsp_x); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        logic [2:0] g;
        bit         to;
        int         rsp_n;
        rsp_n = 0;
        req = 3'b001;
        wait_gnt(g, to);
        total++; if (to || g !== 3'b001) begin bad++; $display("FAIL midrst_gnt: got %b want 001", g); end
        req = 3'b000;
        repeat (50) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy: got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        total++; if ({gnt, rsp_valid, rsp_err, busy, eng_enable} !== 9'b0 || eng_reset !== 1'b1) begin bad++; $display("FAIL midrst_ctrl: got %b rst=%b want 0/1", {gnt, rsp_valid, rsp_err, busy, eng_enable}, eng_reset); end
        total++; if ({rsp_x, rsp_y, eng_theta1, eng_theta2} !== 54'b0) begin bad++; $display("FAIL midrst_data: got %h want 0", {rsp_x, rsp_y, eng_theta1, eng_theta2}); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 3'b000) rsp_n++;
        end
        total++; if (rsp_n != 0) begin bad++; $display("FAIL midrst_no_rsp: got %0d want 0", rsp_n); end
        set_theta(2, 13'd300, 13'd301);
        req = 3'b100;
        wait_gnt(g, to);
        total++; if (to || g !== 3'b100 || eng_theta1 !== 13'sd300) begin bad++; $display("FAIL midrst_regrant: got %b th=%0d want 100/300", g, eng_theta1); end
        req = 3'b000;
        repeat (2) @(negedge clk);
        engine_pulse(14'h1555, 14'h0AAA);
        total++; if (rsp_valid !== 3'b100 || rsp_x !== 14'h1555 || rsp_y !== 14'h0AAA) begin bad++; $display("FAIL midrst_rsp: got v=%b x=%h y=%h want 100/1555/0aaa", rsp_valid, rsp_x, rsp_y); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_withdrawal();
        logic [2:0] g;
        bit         to;
        int         spur;
        spur = 0;
        req = 3'b001;
        wait_gnt(g, to);
        total++; if (to || g !== 3'b001) begin bad++; $display("FAIL wd_gnt: got %b want 001", g); end
        req = 3'b000;
        repeat (2) @(negedge clk);
        req = 3'b100;
        repeat (3) @(negedge clk);
        req = 3'b000;
        repeat (5) @(negedge clk);
        engine_pulse(14'h0042, 14'h0024);
        total++; if (rsp_valid !== 3'b001 || rsp_x !== 14'h0042) begin bad++; $display("FAIL wd_rsp: got v=%b x=%h want 001/0042", rsp_valid, rsp_x); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt !== 3'b000 || rsp_valid !== 3'b000) spur++;
        end
        total++; if (spur != 0) begin bad++; $display("FAIL wd_spurious: got %0d want 0", spur); end
    endtask

`ifdef KIN_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [2:0] g;
        bit         to;
        int         n_rst;
        int         first;
        n_rst = 0;
        first = -1;
        req = 3'b011;
        wait_gnt(g, to);
        total++; if (to || g !== 3'b010) begin bad++; $display("FAIL tmo_gnt: got %b want 010", g); end
        req = 3'b001;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (eng_reset === 1'b1) begin
                if (first < 0) first = i;
                n_rst++;
            end else if (n_rst > 0) begin
                break;
            end
        end
        total++; if (first != 201 || n_rst != 2) begin bad++; $display("FAIL tmo_flush: got start=%0d len=%0d want 201/2", first, n_rst); end
        total++; if (rsp_valid !== 3'b010 || rsp_err !== 1'b1 || {rsp_x, rsp_y} !== 28'b0) begin bad++; $display("FAIL tmo_rsp: got v=%b e=%b xy=%h want 010/1/0", rsp_valid, rsp_err, {rsp_x, rsp_y}); end
        wait_gnt(g, to);
        total++; if (to || g !== 3'b001) begin bad++; $display("FAIL tmo_next_gnt: got %b want 001", g); end
        req = 3'b000;
        repeat (2) @(negedge clk);
        engine_pulse(14'h0777, 14'h0888);
        total++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b0 || rsp_x !== 14'h0777) begin bad++; $display("FAIL tmo_after: got v=%b e=%b x=%h want 001/0/0777", rsp_valid, rsp_err, rsp_x); end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_stretched();
        test_reset_mid_busy();
        test_withdrawal();
`ifdef KIN_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/kinematics_arbiter.md
# kinematics_arbiter

Round-robin scheduler that shares one forward-kinematics engine among `N_REQ` requesters, for example the path planner, the position display and calibration. It latches the granted requester's joint angles and sequences the engine's enable and reset. It captures the engine's `x`/`y` result and returns it to the requester that owns the request. With `KIN_ARB_TIMEOUT_EN` defined, a watchdog also recovers a hung engine.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `ENABLE_HOLD`, 2: cycles `eng_enable` stays high per job (≥2).
- `TIMEOUT`, 200: engine watchdog limit in cycles; used only with `KIN_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  active-low reset, asserted asynchronously, released synchronously.
- `req`  in  `N_REQ`  level request per requester.
- `theta1_in`, `theta2_in`  in  `N_REQ`×13 signed  per-requester joint angles, packed with requester i at `[13*i +: 13]`.
- `gnt`  out  `N_REQ`  one-hot, one-cycle acceptance pulse.
- `rsp_valid`  out  `N_REQ`  one-hot, one-cycle result pulse.
- `rsp_x`, `rsp_y`  out  14  result coordinates; held until the next `rsp_valid`.
- `rsp_err`  out  1  qualifies `rsp_valid`; 1 means the job timed out.
- `busy`  out  1  high in every state except IDLE.
- `eng_theta1`, `eng_theta2`  out  13 signed  latched operands to the engine.
- `eng_enable`  out  1  engine start.
- `eng_reset`  out  1  engine reset, active high.
- `eng_x`, `eng_y`  in  14  engine result.
- `eng_data_ready`  in  1  engine result valid.

## Operation
- States: IDLE, ISSUE, BUSY, DELIVER, DRAIN, and FLUSH (FLUSH exists only with the macro).
- IDLE:
  - If any `req` bit is set, pick the first set bit strictly after `last_id`, wrapping; `last_id` resets to `N_REQ-1`, so requester 0 wins first.
  - Pulse `gnt[id]`, latch `theta1_in`/`theta2_in[id]` into `eng_theta*`, store `id`, go to ISSUE.
- ISSUE: `eng_enable`=1 for `ENABLE_HOLD` cycles, then go to BUSY.
- BUSY:
  - Wait for the first cycle with `eng_data_ready`=1.
  - On that cycle, register `eng_x`/`eng_y` into `rsp_x`/`rsp_y` and go to DELIVER.
- DELIVER:
  - `rsp_valid[id]`=1 and `rsp_err`=0 for one cycle.
  - Set `last_id`=`id`, go to DRAIN.
- DRAIN: wait until `eng_data_ready`=0, then go to IDLE. This prevents a stretched ready from being taken as the next job's result.
- Requester rules:
  - A requester holds `req` and its operands until its `gnt`.
  - Operand changes after `gnt` are ignored.
  - `req` still high after `rsp_valid` is a new request; it waits its round-robin turn.
- Dropping `req` before `gnt` withdraws the request without side effects.
- `eng_theta*` stay constant from grant to DRAIN exit.
- Simultaneous events:
  - A `req` rising in the DELIVER or DRAIN cycle is considered in the next IDLE cycle.
  - `eng_data_ready` high during ISSUE is ignored.

## Timing
- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_x`=`rsp_y`=0, `rsp_err`=0, `busy`=0, `eng_enable`=0, `eng_theta*`=0.
- `eng_reset`: 1 during reset and for 2 cycles after `reset_n` deasserts; 0 otherwise.
- `gnt` is registered: it is high in the cycle after IDLE samples `req`. ISSUE begins in that same cycle.
- `rsp_valid` is high exactly 1 cycle after the capture edge in BUSY.
- Arbiter overhead per job: 1 (grant) + `ENABLE_HOLD` + 1 (deliver) + DRAIN length (≥1) cycles on top of the engine latency.
- Back-to-back jobs from different requesters: at least 4 + `ENABLE_HOLD` cycles of arbiter overhead between grants, excluding the engine's own processing time.
- Reset mid-job:
  - All state returns to IDLE immediately; no `rsp_valid` is issued.
  - `eng_reset` asserts, so the engine is also cleared.

## Configuration
- `KIN_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider cycle counter starts on BUSY entry.
  - If `TIMEOUT` cycles elapse without `eng_data_ready`, go to FLUSH.
  - FLUSH: `eng_reset`=1 for 2 cycles, then `rsp_valid[id]`=1 with `rsp_err`=1 and `rsp_x`=`rsp_y`=0; set `last_id`=`id` and go to IDLE.
  - `eng_data_ready` arriving in the same cycle as expiry wins: normal DELIVER.
- Undefined: no counter and no FLUSH state; BUSY waits indefinitely and `rsp_err` is tied to 0.

## Structure
- Package `kinematics_arbiter_pkg`: the state enum `kin_arb_state_t`, the localparams `THETA_W`=13 and `COORD_W`=14, and `ENG_RESET_CYCLES`=2.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` and `last_id`.
  - Outputs: `id` and `found`.

## Test plan
- Single requester: after reset, req[1]=1 with theta1=100, theta2=−50 → `gnt`=3'b010 one cycle; `eng_theta*`=100/−50; `eng_enable` high 2 cycles; engine model returns x=0x0ABC, y=0x0123 after 114 cycles → `rsp_valid`=3'b010, `rsp_x`=0x0ABC, `rsp_y`=0x0123, `rsp_err`=0.
- Fairness: `req`=3'b111 held continuously → grant order 0,1,2,0,1,2; each result is routed to the matching `rsp_valid` bit.
- Stretched ready: engine holds `eng_data_ready` high 5 cycles → exactly one `rsp_valid`; the next `gnt` comes only after ready falls.
- Reset mid-BUSY: drop `reset_n` at cycle 50 of a job → every output takes its reset value, `eng_reset`=1, no `rsp_valid`; the next request is served normally.
- With `KIN_ARB_TIMEOUT_EN`: silent engine → after `TIMEOUT`=200 cycles `eng_reset` pulses 2 cycles, then `rsp_valid` with `rsp_err`=1 and x=y=0; a pending request is granted next.
- Withdrawal: req[2] rises and falls while requester 0 is in BUSY → requester 2 is never granted and no spurious `rsp_valid` appears.
